// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and FSM state encoding.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// The single shared combinational ALU; signed operands, wrap-around arithmetic.
// Purely combinational, no backpressure.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic [DW-1:0] i_in1,
    input  logic [DW-1:0] i_in2,
    input  logic [CW-1:0] i_ctr,
    output logic [DW-1:0] o_res,
    output logic          o_zero
);

    always_comb begin
        o_res = '0;
        case (i_ctr)
            ALU_AND: o_res = i_in1 & i_in2;
            ALU_OR:  o_res = i_in1 | i_in2;
            ALU_ADD: o_res = i_in1 + i_in2;
            ALU_SUB: o_res = i_in1 - i_in2;
            ALU_SLT: o_res = {{(DW-1){1'b0}}, ($signed(i_in1) < $signed(i_in2))};
            default: o_res = '0;
        endcase
    end

    assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters; result registered in RESP.
// Accept-to-valid 2 cycles, 3-cycle loop; req_ready low outside IDLE and while rsp is stalled.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req_in1_0,
    input  logic [DW-1:0] req_in2_0,
    input  logic [CW-1:0] req_ctr_0,
    input  logic [DW-1:0] req_in1_1,
    input  logic [DW-1:0] req_in2_1,
    input  logic [CW-1:0] req_ctr_1,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_res,
    output logic          rsp_zero
);

    state_t        r_state;
    logic [DW-1:0] r_in1;
    logic [DW-1:0] r_in2;
    logic [CW-1:0] r_ctr;
    logic          r_id;
    logic          r_last_grant;
    logic          r_rsp_valid;
    logic          r_rsp_id;
    logic [DW-1:0] r_rsp_res;
    logic          r_rsp_zero;

    logic [1:0]    w_grant;
    logic          w_accept;
    logic [DW-1:0] w_alu_res;
    logic          w_alu_zero_unused;

    function automatic logic [1:0] rr_arb2(input logic [1:0] vld, input logic last);
        logic [1:0] g;
        case (vld)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    assign w_grant   = rr_arb2(req_valid, r_last_grant);
    // Gated by rst_n so no grant is ever visible while reset is held.
    assign req_ready = (rst_n && (r_state == IDLE)) ? w_grant : 2'b00;
    assign w_accept  = |req_ready;

    alu_arbiter_alu #(.DW(DW), .CW(CW)) u_alu (
        .i_in1  (r_in1),
        .i_in2  (r_in2),
        .i_ctr  (r_ctr),
        .o_res  (w_alu_res),
        .o_zero (w_alu_zero_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in1        <= '0;
            r_in2        <= '0;
            r_ctr        <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_res    <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in1        <= req_ready[1] ? req_in1_1 : req_in1_0;
                        r_in2        <= req_ready[1] ? req_in2_1 : req_in2_0;
                        r_ctr        <= req_ready[1] ? req_ctr_1 : req_ctr_0;
                        r_id         <= req_ready[1];
                        r_last_grant <= req_ready[1];
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_res   <= w_alu_res;
                    r_rsp_zero  <= (w_alu_res == '0);
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cases plus random traffic against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_in1_0, req_in2_0, req_in1_1, req_in2_1;
    logic [3:0]  req_ctr_0, req_ctr_1;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [31:0] rsp_res;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(32), .CW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1_0 (req_in1_0),
        .req_in2_0 (req_in2_0),
        .req_ctr_0 (req_ctr_0),
        .req_in1_1 (req_in1_1),
        .req_in2_1 (req_in2_1),
        .req_ctr_1 (req_ctr_1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_zero  (rsp_zero)
    );

    typedef struct {
        int          acc;
        logic        id;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    int          grant_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_rsp = 0;
    int          acc_port;
    logic        m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] ref_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) return last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // One clock cycle: check outputs mid-cycle against the model, then record events.
    task automatic tick();
        logic [1:0]  eg;
        logic        busy, ev;
        logic [31:0] r;
        #1;
        busy = (q.size() > 0);
        eg   = busy ? 2'b00 : ref_grant(req_valid, m_last);
        chk("req_ready", req_ready, eg);
        ev = busy && (cyc >= q[0].acc + 2);
        chk("rsp_valid", rsp_valid, ev);
        if (ev) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_res", rsp_res, q[0].res);
            chk("rsp_zero", rsp_zero, q[0].res == 32'd0);
        end
        acc_port = -1;
        if (eg != 2'b00) begin
            if (eg[1]) r = alu_ref(req_in1_1, req_in2_1, req_ctr_1);
            else       r = alu_ref(req_in1_0, req_in2_0, req_ctr_0);
            q.push_back('{acc: cyc, id: eg[1], res: r});
            m_last   = eg[1];
            acc_port = eg[1] ? 1 : 0;
            grant_log.push_back(acc_port);
        end else if (ev && rsp_ready) begin
            void'(q.pop_front());
            n_rsp++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c);
        if (p == 0) begin
            req_in1_0 = a; req_in2_0 = b; req_ctr_0 = c; req_valid[0] = 1'b1;
        end else begin
            req_in1_1 = a; req_in2_1 = b; req_ctr_1 = c; req_valid[1] = 1'b1;
        end
    endtask

    task automatic serve(input int max);
        for (int i = 0; i < max; i++) begin
            tick();
            if (acc_port >= 0) req_valid[acc_port] = 1'b0;
            if (q.size() == 0 && req_valid == 2'b00) return;
        end
        checks++;
        errors++;
        $error("FAIL serve_timeout observed=busy expected=drained within %0d cycles", max);
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [1:0] saved;
        saved     = req_valid;
        req_valid = 2'b11;
        #1;
        chk({tag, "_req_ready"}, req_ready, 2'b00);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_id"},    rsp_id,    1'b0);
        chk({tag, "_rsp_res"},   rsp_res,   32'd0);
        chk({tag, "_rsp_zero"},  rsp_zero,  1'b0);
        req_valid = saved;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        q.delete();
        m_last = 1'b1;
        check_reset_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] ops [5];
        ops[0] = 4'b0010; ops[1] = 4'b0110; ops[2] = 4'b0000;
        ops[3] = 4'b0001; ops[4] = 4'b0111;
        if ($urandom_range(0, 5) == 0) return 4'($urandom);
        return ops[$urandom_range(0, 4)];
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 3));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int start_rsp;
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        {req_in1_0, req_in2_0, req_in1_1, req_in2_1} = '0;
        req_ctr_0 = '0;
        req_ctr_1 = '0;
        m_last = 1'b1;
        #2;
        do_reset("reset");

        // Port 0: 5 + 7
        set_req(0, 32'd5, 32'd7, 4'b0010);
        serve(20);

        // Port 1: 3 - 3, then slt -1 < 1
        set_req(1, 32'd3, 32'd3, 4'b0110);
        serve(20);
        set_req(1, 32'hFFFF_FFFF, 32'd1, 4'b0111);
        serve(20);

        // Unknown code, then signed overflow wrap
        set_req(0, 32'hFFFF_FFFF, 32'd1, 4'b1111);
        serve(20);
        set_req(0, 32'h7FFF_FFFF, 32'd1, 4'b0010);
        serve(20);

        // Continuous contention from reset: grants must alternate starting at port 0
        do_reset("pre_contention");
        grant_log.delete();
        set_req(0, rand_opnd(), rand_opnd(), rand_op());
        set_req(1, rand_opnd(), rand_opnd(), rand_op());
        for (int i = 0; i < 36; i++) begin
            tick();
            chk("ready_not_both", req_ready == 2'b11, 1'b0);
            if (acc_port >= 0) set_req(acc_port, rand_opnd(), rand_opnd(), rand_op());
        end
        req_valid = 2'b00;
        serve(20);
        chk("contention_grants", grant_log.size() >= 12, 1'b1);
        for (int i = 0; i < grant_log.size(); i++)
            chk("grant_alternates", grant_log[i], i % 2);

        // Backpressure: result held 5 cycles with both ports requesting
        set_req(0, 32'd100, 32'd58, 4'b0110);
        rsp_ready = 1'b0;
        tick();
        set_req(0, 32'd1, 32'd2, 4'b0010);
        set_req(1, 32'd9, 32'd9, 4'b0001);
        tick();
        for (int i = 0; i < 5; i++) tick();
        req_valid = 2'b00;
        start_rsp = n_rsp;
        rsp_ready = 1'b1;
        tick();
        chk("single_release", n_rsp - start_rsp, 1);
        tick();

        // Reset during EXEC drops the op; next port 0 request is served normally
        set_req(0, 32'd40, 32'd2, 4'b0010);
        tick();
        req_valid = 2'b00;
        start_rsp = n_rsp;
        do_reset("exec_reset");
        for (int i = 0; i < 4; i++) tick();
        chk("dropped_no_rsp", n_rsp - start_rsp, 0);
        set_req(0, 32'd11, 32'd22, 4'b0001);
        serve(20);
        chk("after_reset_rsp", n_rsp - start_rsp, 1);

        // Random traffic with drops and random backpressure
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p]) begin
                    if ($urandom_range(0, 1) == 1) set_req(p, rand_opnd(), rand_opnd(), rand_op());
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[p] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (acc_port >= 0) req_valid[acc_port] = 1'b0;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        serve(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
